inertial_integrator: RTL

INERTIAL_INTEGRATOR -- requirements
Module: inertial_integrator

---
 rtl/segway_pkg.sv | 17 +
 rtl/gyro_offset_cal.sv | 44 ++++
 rtl/inertial_integrator.sv | 85 ++++++++
 3 files changed

// File: rtl/segway_pkg.sv
// rtl/segway_pkg.sv - shared types and constants for the segway balance datapath
package segway_pkg;

  typedef enum logic [0:0] {
    CAL = 1'b0,
    RUN = 1'b1
  } state_t;

  // Accelerometer-to-angle gain, applied before a >>>13.
  localparam int ACC_GAIN = 327;

  function automatic logic signed [15:0] sat16(input logic signed [16:0] v);
    if (v[16] != v[15]) return v[16] ? 16'sh8000 : 16'sh7FFF;
    else return v[15:0];
  endfunction

endpackage

// File: rtl/gyro_offset_cal.sv
// rtl/gyro_offset_cal.sv - averages 2^CAL_SAMPLES_LOG2 gyro samples into a rate offset
module gyro_offset_cal
  import segway_pkg::*;
#(
  parameter int CAL_SAMPLES_LOG2 = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  input  logic                sample,
  input  logic signed [15:0]  rate_raw,
  output logic signed [15:0]  offset,
  output logic                last
);

  logic signed [19:0]          acc;
  logic signed [19:0]          acc_next;
  logic [CAL_SAMPLES_LOG2-1:0] cnt;

  assign acc_next = acc + 20'(rate_raw);
  assign last     = sample && (&cnt);

  always_ff @(posedge clk) begin
    if (rst) begin
      acc    <= '0;
      cnt    <= '0;
      offset <= '0;
    end else if (clr) begin
      acc <= '0;
      cnt <= '0;
    end else if (sample) begin
      if (last) begin
        // The completing sample is part of the average.
        offset <= 16'(acc_next >>> CAL_SAMPLES_LOG2);
        acc    <= '0;
        cnt    <= '0;
      end else begin
        acc <= acc_next;
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/inertial_integrator.sv
// rtl/inertial_integrator.sv - gyro/accel complementary pitch integrator feeding the PID
module inertial_integrator
  import segway_pkg::*;
#(
  parameter logic signed [15:0] AZ_OFFSET        = 16'shFE80,
  parameter int                 FUSION_STEP      = 1024,
  parameter int                 CAL_SAMPLES_LOG2 = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               vld,
  input  logic               recal,
  input  logic signed [15:0] ptch_rt_raw,
  input  logic signed [15:0] AZ,
  output logic signed [15:0] ptch,
  output logic signed [15:0] ptch_rt,
  output logic               ptch_vld,
  output logic               cal_done
);

  state_t             state;
  logic signed [26:0] integ;
  logic signed [15:0] offset;
  logic               cal_last;
  logic               cal_sample;
  logic               run_sample;

  logic signed [16:0] rate_diff;
  logic signed [15:0] rate_corr;
  logic signed [16:0] az_diff;
  logic signed [26:0] acc_prod;
  logic signed [15:0] ptch_acc;
  logic signed [26:0] fusion;
  logic signed [26:0] integ_next;

  // recal dominates a coincident vld: the sample is dropped entirely.
  assign cal_sample = vld && !recal && (state == CAL);
  assign run_sample = vld && !recal && (state == RUN);
  assign cal_done   = (state == RUN);

  gyro_offset_cal #(
    .CAL_SAMPLES_LOG2(CAL_SAMPLES_LOG2)
  ) u_cal (
    .clk      (clk),
    .rst      (rst),
    .clr      (recal),
    .sample   (cal_sample),
    .rate_raw (ptch_rt_raw),
    .offset   (offset),
    .last     (cal_last)
  );

  assign rate_diff = {ptch_rt_raw[15], ptch_rt_raw} - {offset[15], offset};
  assign rate_corr = sat16(rate_diff);

  // 17-bit difference times a 10-bit gain fits in 27 bits without overflow.
  assign az_diff  = {AZ[15], AZ} - {AZ_OFFSET[15], AZ_OFFSET};
  assign acc_prod = 27'(az_diff) * 27'(ACC_GAIN);
  assign ptch_acc = 16'(acc_prod >>> 13);

  assign fusion     = (ptch_acc > ptch) ? 27'(FUSION_STEP) : -27'(FUSION_STEP);
  assign integ_next = integ - 27'(rate_corr) + fusion;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= CAL;
      integ    <= '0;
      ptch     <= '0;
      ptch_rt  <= '0;
      ptch_vld <= 1'b0;
    end else begin
      ptch_vld <= 1'b0;
      if (recal) state <= CAL;
      else if (cal_last) state <= RUN;

      if (run_sample) begin
        ptch_rt  <= rate_corr;
        integ    <= integ_next;
        ptch     <= integ_next[26:11];
        ptch_vld <= 1'b1;
      end
    end
  end

endmodule
